// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg -- shared definitions for the AES-128 round sequencer.
//   state_t    : FSM state encoding (3-bit)
//   NR         : number of AES-128 rounds
//   RCON_*     : first / last Rcon values and the GF(2^8) reduction constant
//   xtime()    : multiply-by-x in GF(2^8), used to step Rcon
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_LAST = 8'h36;
    localparam logic [7:0] RCON_RED  = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_RED : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen -- registered Rcon generator.
//   clock, reset_n : clock / async active-low reset (rcon resets to 00)
//   clr            : synchronous clear to 00 (block cancelled)
//   load           : reload RCON_INIT for a new block
//   adv            : step rcon by xtime; saturates at RCON_LAST
//   rcon           : current round constant
// Priority: clr > load > adv.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       load,
    input  logic       adv,
    output logic [7:0] rcon
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rcon <= 8'h00;
        end else if (clr) begin
            rcon <= 8'h00;
        end else if (load) begin
            rcon <= RCON_INIT;
        end else if (adv && rcon != RCON_LAST) begin
            // Round 10 uses 36; never step beyond it.
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- sequencer for the iterative AES-128 encryption datapath.
// Walks INIT (AddRoundKey) -> rounds 1..9 -> final round 10 -> DONE, driving
// datapath strobes, round index and Rcon. Start/done are valid/ready.
//   clock, reset_n          : clock / async active-low reset
//   start_valid/start_ready : block-start handshake (start_ready is combinational)
//   abort                   : synchronous cancel, highest priority
//   state_load, key_load    : load plaintext^key / cipher key (INIT)
//   round_en                : advance datapath and key expansion one round
//   sel_final, cap_en       : final round (no MixColumns) and output capture
//   round_idx, rcon         : current round number and round constant
//   busy                    : not idle
//   done_valid/done_ready   : result handshake
// Optional build macro AES_ROUND_CTRL_BLKCNT_EN adds blk_cnt[CNT_W-1:0],
// a wrapping count of completed (handshaken, not aborted) blocks.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       abort,
    output logic       state_load,
    output logic       key_load,
    output logic       round_en,
    output logic       sel_final,
    output logic       cap_en,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    ,
    output logic [CNT_W-1:0] blk_cnt
`endif
);

    import aes_ctrl_pkg::*;

    if (NR != aes_ctrl_pkg::NR) begin : g_bad_nr
        $error("aes_round_ctrl: only NR=10 (AES-128) is supported");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("aes_round_ctrl: CNT_W must be at least 1");
    end

    state_t state;
    logic   start_acc;

    // A new block may start from IDLE, or from DONE in the same cycle the
    // result is taken, which gives back-to-back blocks with no bubble.
    assign start_ready = ~abort & ((state == ST_IDLE) |
                                   ((state == ST_DONE) & done_ready));
    assign start_acc   = start_valid & start_ready;

    // INIT and round 1 both use Rcon 01, so only ROUND steps it.
    aes_rcon_gen u_rcon (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (abort),
        .load    (start_acc),
        .adv     (state == ST_ROUND),
        .rcon    (rcon)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            round_idx  <= 4'd0;
            state_load <= 1'b0;
            key_load   <= 1'b0;
            round_en   <= 1'b0;
            sel_final  <= 1'b0;
            cap_en     <= 1'b0;
            busy       <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            state_load <= 1'b0;
            key_load   <= 1'b0;
            round_en   <= 1'b0;
            sel_final  <= 1'b0;
            cap_en     <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                round_idx  <= 4'd0;
                busy       <= 1'b0;
                done_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_acc) begin
                            state      <= ST_INIT;
                            state_load <= 1'b1;
                            key_load   <= 1'b1;
                            round_idx  <= 4'd0;
                            busy       <= 1'b1;
                        end
                    end
                    ST_INIT: begin
                        state     <= ST_ROUND;
                        round_en  <= 1'b1;
                        round_idx <= 4'd1;
                    end
                    ST_ROUND: begin
                        round_en <= 1'b1;
                        if (round_idx == 4'(NR - 1)) begin
                            state     <= ST_FINAL;
                            sel_final <= 1'b1;
                            cap_en    <= 1'b1;
                            round_idx <= 4'(NR);
                        end else begin
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                    ST_FINAL: begin
                        state      <= ST_DONE;
                        done_valid <= 1'b1;
                    end
                    ST_DONE: begin
                        if (done_ready) begin
                            done_valid <= 1'b0;
                            if (start_acc) begin
                                state      <= ST_INIT;
                                state_load <= 1'b1;
                                key_load   <= 1'b1;
                                round_idx  <= 4'd0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        done_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef AES_ROUND_CTRL_BLKCNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= '0;
        end else if (done_valid & done_ready & ~abort) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl -- self-checking bench for aes_round_ctrl.
// Table of per-cycle {inputs, expected outputs} records, replayed through a
// scoreboard queue, plus hand-written abort / reset / IDLE-abort sequences.
module tb_aes_round_ctrl;

`ifdef AES_ROUND_CTRL_BLKCNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_ROUND = 2;
    localparam int P_FINAL = 3;
    localparam int P_DONE  = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_valid, start_ready, abort;
    logic       state_load, key_load, round_en, sel_final, cap_en;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       busy, done_valid, done_ready;
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    logic [CNT_W-1:0] blk_cnt;
`endif

    aes_round_ctrl #(.NR(10), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .state_load  (state_load),
        .key_load    (key_load),
        .round_en    (round_en),
        .sel_final   (sel_final),
        .cap_en      (cap_en),
        .round_idx   (round_idx),
        .rcon        (rcon),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        ,
        .blk_cnt     (blk_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       sl, kl, re, sf, ce, bsy, dv;
        logic [3:0] idx;
        logic [7:0] rc;
    } out_t;

    typedef struct {
        logic sv, dr, ab;
        out_t exp;
    } vec_t;

    vec_t       vecs[$];
    out_t       exp_q[$];
    logic [7:0] rc_tab [0:10];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    function automatic out_t mk(input int ph, input int r);
        out_t o;
        o = '0;
        case (ph)
            P_INIT:  begin o.sl = 1; o.kl = 1; o.bsy = 1; o.idx = 4'd0; o.rc = rc_tab[0]; end
            P_ROUND: begin o.re = 1; o.bsy = 1; o.idx = 4'(r); o.rc = rc_tab[r]; end
            P_FINAL: begin o.re = 1; o.sf = 1; o.ce = 1; o.bsy = 1; o.idx = 4'd10; o.rc = rc_tab[10]; end
            P_DONE:  begin o.dv = 1; o.bsy = 1; o.idx = 4'd10; o.rc = rc_tab[10]; end
            default: begin o.idx = 4'd10; o.rc = rc_tab[10]; end
        endcase
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o.sl = state_load; o.kl = key_load; o.re = round_en; o.sf = sel_final;
        o.ce = cap_en; o.bsy = busy; o.dv = done_valid; o.idx = round_idx; o.rc = rcon;
        return o;
    endfunction

    task automatic add(input logic sv, input logic dr, input logic ab, input int ph, input int r);
        vec_t v;
        v.sv = sv; v.dr = dr; v.ab = ab; v.exp = mk(ph, r);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        else pass_cnt++;
    endtask

    task automatic run_range(input int lo, input int hi);
        out_t e;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clock);
            start_valid = vecs[i].sv;
            done_ready  = vecs[i].dr;
            abort       = vecs[i].ab;
            exp_q.push_back(vecs[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d {sl,kl,re,sf,ce,bsy,dv,idx,rc}", i), 32'(cur()), 32'(e));
        end
    endtask

    task automatic wait_idx(input int n);
        for (int i = 0; i < 20; i++) begin
            if (round_idx == 4'(n)) break;
            @(posedge clock);
            #1;
        end
        chk($sformatf("reach_round%0d", n), 32'(round_idx), 32'(n));
    endtask

    task automatic start_block();
        @(negedge clock);
        start_valid = 1; done_ready = 0; abort = 0;
        @(posedge clock);
        #1;
        @(negedge clock);
        start_valid = 0;
    endtask

    initial begin
        logic bad;
        rc_tab = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

        // rows 0..17: single block, 5 cycles back-pressure, then release
        add(1, 0, 0, P_INIT, 0);
        for (int r = 1; r <= 9; r++) add(0, 0, 0, P_ROUND, r);
        add(0, 0, 0, P_FINAL, 10);
        for (int k = 0; k < 6; k++) add(0, 0, 0, P_DONE, 10);
        add(0, 1, 0, P_IDLE, 10);
        // rows 18..42: two back-to-back blocks in 24 cycles, then idle
        for (int k = 0; k < 24; k++) begin
            case (k % 12)
                0:       add(1, 1, 0, P_INIT, 0);
                10:      add(1, 1, 0, P_FINAL, 10);
                11:      add(1, 1, 0, P_DONE, 10);
                default: add(1, 1, 0, P_ROUND, k % 12);
            endcase
        end
        add(0, 1, 0, P_IDLE, 10);

        reset_n = 0; start_valid = 0; abort = 0; done_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", 32'(cur()), 32'h0);
        chk("reset_start_ready", 32'(start_ready), 32'h1);
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        #1;
        chk("idle_after_reset", 32'(cur()), 32'h0);
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        chk("blk_cnt_reset", 32'(blk_cnt), 32'h0);
`endif

        run_range(0, 12);
        chk("start_ready_backpressure", 32'(start_ready), 32'h0);
        run_range(13, 17);
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        chk("blk_cnt_one", 32'(blk_cnt), 32'h1);
`endif
        run_range(18, 29);
        chk("start_ready_done_ready", 32'(start_ready), 32'h1);
        run_range(30, 42);
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        chk("blk_cnt_three", 32'(blk_cnt), 32'h3);
`endif

        // abort together with start in IDLE: no start accepted
        @(negedge clock);
        start_valid = 1; abort = 1; done_ready = 0;
        #1;
        chk("idle_abort_start_ready", 32'(start_ready), 32'h0);
        @(posedge clock);
        #1;
        chk("idle_abort_no_init", 32'({busy, state_load, key_load}), 32'h0);
        @(negedge clock);
        start_valid = 0; abort = 0;

        // abort at round 5
        start_block();
        wait_idx(5);
        @(negedge clock);
        abort = 1;
        @(posedge clock);
        #1;
        chk("abort_r5_idle",
            32'({busy, done_valid, cap_en, round_en, sel_final, state_load, key_load}), 32'h0);
        @(negedge clock);
        abort = 0;
        bad = 0;
        repeat (14) begin
            @(posedge clock);
            #1;
            if (cap_en | done_valid | busy) bad = 1;
        end
        chk("abort_no_result", 32'(bad), 32'h0);
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        chk("blk_cnt_after_abort", 32'(blk_cnt), 32'h3);
`endif

        // async reset at round 7, checked before the next clock edge
        start_block();
        wait_idx(7);
        #2;
        reset_n = 0;
        #1;
        chk("async_reset_outputs", 32'(cur()), 32'h0);
        chk("async_reset_start_ready", 32'(start_ready), 32'h1);
        @(negedge clock);
        reset_n = 1;
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        chk("blk_cnt_after_reset", 32'(blk_cnt), 32'h0);
`endif
        run_range(0, 11);
        run_range(17, 17);

`ifdef AES_ROUND_CTRL_BLKCNT_EN
        // four more blocks: 5 completions wrap a 2-bit count to 1
        for (int b = 0; b < 4; b++) begin
            run_range(0, 11);
            run_range(17, 17);
        end
        chk("blk_cnt_wrap", 32'(blk_cnt), 32'h1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
